// File: rtl/servo_cmd_sequencer_pkg.sv
// Shared definitions for the gripper servo command sequencer: command codes,
// FSM state encoding and counter widths.
package servo_cmd_sequencer_pkg;

  // Codes understood by the servo PWM generator's cmd input.
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_0DEG  = 2'b01;
  localparam logic [1:0] CMD_90DEG = 2'b10;

  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned HOLD_CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StIssue  = 2'b01,
    StSettle = 2'b10,
    StAck    = 2'b11
  } state_t;

  // Map a target position (0 = 0 deg, 1 = 90 deg) to its servo command.
  function automatic logic [1:0] cmd_for_pos(input logic pos);
    return pos ? CMD_90DEG : CMD_0DEG;
  endfunction

endpackage

// File: rtl/servo_cmd_sequencer_if.sv
// Requester / servo-side signal bundle of the servo command sequencer.
interface servo_cmd_sequencer_if;
  logic [1:0] req;
  logic       pos0;
  logic       pos1;
  logic [1:0] ack;
  logic       busy;
  logic       grant_id;
  logic [1:0] servo_cmd;
  logic       cur_pos;
  logic       pos_valid;

  // Requester / environment side.
  modport master (
    output req, pos0, pos1,
    input  ack, busy, grant_id, servo_cmd, cur_pos, pos_valid
  );

  // Sequencer side.
  modport slave (
    input  req, pos0, pos1,
    output ack, busy, grant_id, servo_cmd, cur_pos, pos_valid
  );
endinterface

// File: rtl/servo_cmd_sequencer_frame_settle_timer.sv
// Settle timer: counts SETTLE_FRAMES whole PWM frames of FRAME_CYCLES clocks.
// The cycle in which i_start is high is the first counted cycle; o_done is high
// in the last counted cycle (the one ending in the final frame wrap).
module servo_cmd_sequencer_frame_settle_timer
  import servo_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES  = 1000000,
  parameter int unsigned SETTLE_FRAMES = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_done
);

  localparam int unsigned CycW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CycW-1:0]        CycLast = CycW'(FRAME_CYCLES - 1);
  localparam logic [FRAME_CNT_W-1:0] FrmLast = FRAME_CNT_W'(SETTLE_FRAMES - 1);

  logic                   r_run;
  logic [CycW-1:0]        r_cyc;
  logic [FRAME_CNT_W-1:0] r_frm;

  logic                   w_active;
  logic                   w_wrap;
  logic [CycW-1:0]        w_cyc_cur;
  logic [FRAME_CNT_W-1:0] w_frm_cur;

  // A start restarts counting from zero even if a previous run was pending.
  assign w_active  = i_start | r_run;
  assign w_cyc_cur = i_start ? '0 : r_cyc;
  assign w_frm_cur = i_start ? '0 : r_frm;
  assign w_wrap    = w_active && (w_cyc_cur == CycLast);
  assign o_done    = w_wrap && (w_frm_cur == FrmLast);

  // Cycle counter wraps every frame; frame counter advances on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
      r_cyc <= '0;
      r_frm <= '0;
    end else if (w_active) begin
      if (o_done) begin
        r_run <= 1'b0;
        r_cyc <= '0;
        r_frm <= '0;
      end else begin
        r_run <= 1'b1;
        if (w_wrap) begin
          r_cyc <= '0;
          r_frm <= w_frm_cur + 8'd1;
        end else begin
          r_cyc <= w_cyc_cur + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Shares the gripper servo between two requesters: round-robin grant, a
// CMD_HOLD-cycle command pulse, a settle wait of whole PWM frames, then a
// one-cycle ack to the winner. All interface outputs are registered.
module servo_cmd_sequencer
  import servo_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES  = 1000000,
  parameter int unsigned SETTLE_FRAMES = 25,
  parameter int unsigned CMD_HOLD      = 4
) (
  input logic                  clk,
  input logic                  rst,
  servo_cmd_sequencer_if.slave bus
);

  localparam logic [HOLD_CNT_W-1:0] HoldLast = HOLD_CNT_W'(CMD_HOLD);

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_grant_id;
  logic                  r_target;
  logic                  r_busy;
  logic [1:0]            r_ack;
  logic [1:0]            r_servo_cmd;
  logic                  r_cur_pos;
  logic                  r_pos_valid;
  logic [HOLD_CNT_W-1:0] r_hold;

  logic w_winner;
  logic w_pos_sel;
  logic w_start;
  logic w_done;

  // Round-robin arbiter: a tie goes to the requester not served last.
  always_comb begin
    w_winner = 1'b0;
    case (bus.req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last_grant;
      default: w_winner = 1'b0;
    endcase
    w_pos_sel = w_winner ? bus.pos1 : bus.pos0;
  end

  // Settle timing starts in the last command cycle so the ack lands on time.
  assign w_start = (r_state == StIssue) && (r_hold == HoldLast);

  servo_cmd_sequencer_frame_settle_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .SETTLE_FRAMES(SETTLE_FRAMES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .o_done (w_done)
  );

  // Main sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_target     <= 1'b0;
      r_busy       <= 1'b0;
      r_ack        <= 2'b00;
      r_servo_cmd  <= CMD_NONE;
      r_cur_pos    <= 1'b0;
      r_pos_valid  <= 1'b0;
      r_hold       <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (|bus.req) begin
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_target     <= w_pos_sel;
            r_busy       <= 1'b1;
            r_hold       <= '0;
            r_state      <= StIssue;
          end
        end
        StIssue: begin
          // First ISSUE cycle decides skip vs. move on the latched target.
          if (r_hold == '0) begin
            if (r_pos_valid && (r_target == r_cur_pos)) begin
              r_state <= StAck;
            end else begin
              r_servo_cmd <= cmd_for_pos(r_target);
              r_hold      <= 4'd1;
            end
          end else if (r_hold == HoldLast) begin
            r_servo_cmd <= CMD_NONE;
            r_hold      <= '0;
            r_state     <= StSettle;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        StSettle: begin
          if (w_done) begin
            r_cur_pos   <= r_target;
            r_pos_valid <= 1'b1;
            r_state     <= StAck;
          end
        end
        StAck: begin
          // Stay here through the ack cycle so req is not resampled while it pulses.
          if (r_ack == 2'b00) begin
            r_ack <= r_grant_id ? 2'b10 : 2'b01;
          end else begin
            r_ack   <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;
  assign bus.servo_cmd = r_servo_cmd;
  assign bus.cur_pos   = r_cur_pos;
  assign bus.pos_valid = r_pos_valid;

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Scoreboard bench for servo_cmd_sequencer: the driver predicts each grant with
// a transaction-level model and queues it; a monitor checks every ack.
module tb_servo_cmd_sequencer;

  localparam int unsigned FRAME_CYCLES  = 10;
  localparam int unsigned SETTLE_FRAMES = 3;
  localparam int unsigned CMD_HOLD      = 2;
  localparam int MOVE_LAT = CMD_HOLD + SETTLE_FRAMES * FRAME_CYCLES + 1;
  localparam int SKIP_LAT = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  servo_cmd_sequencer_if bus ();

  servo_cmd_sequencer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .SETTLE_FRAMES(SETTLE_FRAMES),
    .CMD_HOLD     (CMD_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0] ack;
    logic       gid;
    logic       move;
    logic [1:0] cmd;
    int         lat;
    logic       cur;
    bit         b2b;
  } exp_t;

  exp_t q[$];

  // Reference model state: what the servo was last told, and round-robin memory.
  bit m_last;
  bit m_cur;
  bit m_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_last  = 1'b1;
    m_cur   = 1'b0;
    m_valid = 1'b0;
    q.delete();
  endfunction

  // One grant to requester w with target tgt: skip if servo is already there.
  function automatic void push_grant(input bit w, input bit tgt, input bit b2b);
    exp_t e;
    e.move = !(m_valid && (tgt == m_cur));
    e.ack  = w ? 2'b10 : 2'b01;
    e.gid  = w;
    e.cmd  = e.move ? (tgt ? 2'b10 : 2'b01) : 2'b00;
    e.lat  = e.move ? MOVE_LAT : SKIP_LAT;
    e.cur  = tgt;
    e.b2b  = b2b;
    q.push_back(e);
    m_last  = w;
    m_cur   = tgt;
    m_valid = 1'b1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},       32'(bus.ack),       0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_grant_id"},  32'(bus.grant_id),  0);
    check({tag, "_servo_cmd"}, 32'(bus.servo_cmd), 0);
    check({tag, "_cur_pos"},   32'(bus.cur_pos),   0);
    check({tag, "_pos_valid"}, 32'(bus.pos_valid), 0);
  endtask

  task automatic wait_ack(output logic [1:0] a);
    a = 2'b00;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        a = bus.ack;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: got no ack expected an ack within 200 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_busy();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL busy_timeout: got busy=0 expected busy=1 within 20 cycles (cycle %0d)", cyc);
  endtask

  // Async reset pulse asserted mid-cycle; outputs must clear immediately.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.req = 2'b00;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Raise a request mask, predict the service order and drop each bit on its ack.
  task automatic do_round(input logic [1:0] mask, input bit p0, input bit p1);
    logic [1:0] a;
    int         n;
    bit         w;
    @(negedge clk);
    bus.pos0 = p0;
    bus.pos1 = p1;
    bus.req  = mask;
    if (mask == 2'b11) begin
      w = ~m_last;
      push_grant(w, w ? p1 : p0, 1'b0);
      push_grant(~w, w ? p0 : p1, 1'b1);
      n = 2;
    end else begin
      w = mask[1];
      push_grant(w, w ? p1 : p0, 1'b0);
      n = 1;
    end
    for (int i = 0; i < n; i++) begin
      wait_ack(a);
      if (a == 2'b00) begin
        bus.req = 2'b00;
        return;
      end
      bus.req = bus.req & ~a;
    end
  endtask

  // Monitor: tracks each grant's command activity and checks it at the ack.
  initial begin
    bit         prev_busy;
    bit         after_ack;
    int         k;
    int         last_ack;
    int         n_cmd;
    int         first_cmd;
    logic [1:0] cmd_val;
    exp_t       e;
    prev_busy = 1'b0;
    after_ack = 1'b0;
    k = 0;
    last_ack = 0;
    n_cmd = 0;
    first_cmd = -1;
    cmd_val = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        after_ack = 1'b0;
        continue;
      end
      if (after_ack) begin
        check("busy_low_after_ack", 32'(bus.busy), 0);
        after_ack = 1'b0;
      end
      if (bus.busy && !prev_busy) begin
        k = cyc;
        n_cmd = 0;
        first_cmd = -1;
        cmd_val = 2'b00;
        if (q.size() > 0 && q[0].b2b) check("pending_grant_gap", 32'(cyc - last_ack), 2);
      end
      if (bus.servo_cmd != 2'b00) begin
        n_cmd++;
        cmd_val = bus.servo_cmd;
        if (first_cmd < 0) first_cmd = cyc;
      end
      if (bus.ack != 2'b00) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack=%0d expected no ack (cycle %0d)", bus.ack, cyc);
        end else begin
          e = q.pop_front();
          check("ack_value",    32'(bus.ack),       32'(e.ack));
          check("ack_grant_id", 32'(bus.grant_id),  32'(e.gid));
          check("ack_busy",     32'(bus.busy),      1);
          check("ack_latency",  32'(cyc - k),       32'(e.lat));
          check("cmd_cycles",   32'(n_cmd),         e.move ? CMD_HOLD : 0);
          check("cmd_value",    32'(cmd_val),       32'(e.cmd));
          check("cur_pos",      32'(bus.cur_pos),   32'(e.cur));
          check("pos_valid",    32'(bus.pos_valid), 1);
          if (e.move) check("cmd_start", 32'(first_cmd - k), 1);
        end
        last_ack = cyc;
        after_ack = 1'b1;
      end
      prev_busy = bus.busy;
    end
  end

  // Stimulus.
  initial begin
    logic [1:0] a;
    bit         p;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus.req  = 2'b00;
    bus.pos0 = 1'b0;
    bus.pos1 = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Abandon a move by reset, then a full move to 90 deg by requester 0.
    @(negedge clk);
    bus.pos1 = 1'b1;
    bus.req  = 2'b10;
    wait_busy();
    repeat (2) @(negedge clk);
    mid_reset("rst_issue");
    do_round(2'b01, 1'b1, 1'b0);

    // Same target again: skip path.
    repeat (2) @(negedge clk);
    do_round(2'b01, 1'b1, 1'b0);

    // Tie from reset: requester 0 first, then the pending requester 1.
    mid_reset("rst_tie");
    do_round(2'b11, 1'b0, 1'b1);

    // Both held through three grants: strict alternation.
    repeat (2) @(negedge clk);
    bus.pos0 = 1'b1;
    bus.pos1 = 1'b0;
    bus.req  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      p = ~m_last;
      push_grant(p, p ? bus.pos1 : bus.pos0, i > 0);
    end
    for (int i = 0; i < 3; i++) begin
      wait_ack(a);
      if (a == 2'b00) break;
    end
    bus.req = 2'b00;

    // Reset during SETTLE abandons the move; the re-request is a full move.
    repeat (2) @(negedge clk);
    bus.pos1 = ~m_cur;
    p        = ~m_cur;
    bus.req  = 2'b10;
    wait_busy();
    repeat (CMD_HOLD + 8) @(negedge clk);
    mid_reset("rst_settle");
    do_round(2'b10, 1'b0, p);

    // Requester 1 drops req after grant and changes pos mid-settle.
    repeat (2) @(negedge clk);
    p        = ~m_cur;
    bus.pos1 = p;
    bus.req  = 2'b10;
    push_grant(1'b1, p, 1'b0);
    wait_busy();
    bus.req = 2'b00;
    repeat (CMD_HOLD + 12) @(negedge clk);
    bus.pos1 = ~p;
    wait_ack(a);

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      do_round(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
